// File: rtl/irq_controller_if.sv
// Processor-side bundle for the interrupt controller.
// Holds the CPU interrupt handshake and the 8-bit register bus.
interface irq_controller_if;
   logic       CPU_INT_RAISE;
   logic [2:0] CPU_INT_ID;
   logic       CPU_INT_ACK;
   logic [7:0] BUS_ADDR;
   logic [7:0] BUS_DATA_IN;
   logic       BUS_WE;
   logic [7:0] BUS_DATA_OUT;

   modport master (
      output CPU_INT_ACK, BUS_ADDR, BUS_DATA_IN, BUS_WE,
      input  CPU_INT_RAISE, CPU_INT_ID, BUS_DATA_OUT
   );

   modport slave (
      input  CPU_INT_ACK, BUS_ADDR, BUS_DATA_IN, BUS_WE,
      output CPU_INT_RAISE, CPU_INT_ID, BUS_DATA_OUT
   );
endinterface

// File: rtl/irq_controller.sv
// Interrupt scheduler: edge-detected pending bits, mask, fixed
// priority (lowest index wins), one raise at a time with timeout.
module irq_controller #(
   parameter int       N_SRC     = 4,
   parameter bit [7:0] BASE_ADDR = 8'hC0,
   parameter int       TIMEOUT   = 1023,
   parameter int       HOLDOFF   = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [N_SRC-1:0] IRQ_IN,
   output logic [N_SRC-1:0] IRQ_ACK_OUT,
   irq_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RAISE,
      S_ACK,
      S_HOLD
   } state_t;

   localparam logic [7:0]  PEND_ADDR = BASE_ADDR + 8'd1;
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [15:0] HOLD_LAST =
      (HOLDOFF == 0) ? 16'd0 : 16'(HOLDOFF - 1);

   state_t           r_state;
   state_t           w_next;
   logic [N_SRC-1:0] r_sync1;
   logic [N_SRC-1:0] r_sync2;
   logic [N_SRC-1:0] r_prev;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_mask;
   logic [2:0]       r_id;
   logic [15:0]      r_cnt;
   logic [7:0]       r_rdata;
   logic [N_SRC-1:0] w_rise;
   logic [N_SRC-1:0] w_avail;
   logic [N_SRC-1:0] w_clr;
   logic [2:0]       w_sel;
   logic             w_hit_mask;
   logic             w_hit_pend;
   logic             w_unused;

   assign w_rise     = r_sync2 & ~r_prev;
   assign w_avail    = r_pending & ~r_mask;
   assign w_hit_mask = (bus.BUS_ADDR == BASE_ADDR);
   assign w_hit_pend = (bus.BUS_ADDR == PEND_ADDR);
   assign w_unused   = ^bus.BUS_DATA_IN;

   // Descending scan so the lowest set index is the last to assign.
   always_comb begin
      w_sel = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_avail[i]) w_sel = 3'(i);
      end
   end

   always_comb begin
      w_clr = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_clr[i] = (r_state == S_ACK) && (r_id == 3'(i));
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (|w_avail) w_next = S_RAISE;
         S_RAISE: begin
            if (bus.CPU_INT_ACK)        w_next = S_ACK;
            else if (r_cnt == TMO_LAST) w_next = S_HOLD;
         end
         S_ACK:   w_next = S_HOLD;
         S_HOLD:  if (r_cnt == HOLD_LAST) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.CPU_INT_RAISE = (r_state == S_RAISE);
      bus.CPU_INT_ID    = (r_state == S_RAISE) ? r_id : 3'd0;
      IRQ_ACK_OUT       = w_clr;
      bus.BUS_DATA_OUT  = r_rdata;
   end

   // One counter serves both the raise timeout and the holdoff.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cnt <= 16'd0;
         r_id  <= 3'd0;
      end else begin
         if (w_next != r_state) r_cnt <= 16'd0;
         else                   r_cnt <= r_cnt + 16'd1;
         if (r_state == S_IDLE && |w_avail) r_id <= w_sel;
      end
   end

   // A fresh edge outranks the ack clear on the same bit.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_prev    <= '0;
         r_pending <= '0;
      end else begin
         r_sync1   <= IRQ_IN;
         r_sync2   <= r_sync1;
         r_prev    <= r_sync2;
         r_pending <= (r_pending & ~w_clr) | w_rise;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_mask  <= '0;
         r_rdata <= 8'd0;
      end else begin
         if (bus.BUS_WE && w_hit_mask)
            r_mask <= bus.BUS_DATA_IN[N_SRC-1:0];
         if (bus.BUS_WE)      r_rdata <= 8'd0;
         else if (w_hit_mask) r_rdata <= 8'(r_mask);
         else if (w_hit_pend) r_rdata <= 8'(r_pending);
         else                 r_rdata <= 8'd0;
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register vector table, scoreboarded
// read data and ack pulses, plus multi-cycle scheduling sequences.
module tb_irq_controller;

   localparam int N   = 4;
   localparam int TMO = 1023;
   localparam int HO  = 2;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [3:0] IRQ_IN = 4'd0;
   logic [3:0] IRQ_ACK_OUT;

   irq_controller_if bus();

   irq_controller #(
      .N_SRC(N), .BASE_ADDR(8'hC0),
      .TIMEOUT(TMO), .HOLDOFF(HO)
   ) dut (
      .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN),
      .IRQ_ACK_OUT(IRQ_ACK_OUT), .bus(bus)
   );

   always #5 CLK = ~CLK;

   int n_pass  = 0;
   int n_total = 0;
   logic [7:0] rd_q[$];
   logic [3:0] ack_q[$];

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[11];

   task automatic check(string name, logic [31:0] act,
                        logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Entered and left at a negedge; read data checked after the edge.
   task automatic bus_cycle(logic we, logic [7:0] addr,
                            logic [7:0] data, logic [7:0] exp,
                            string name);
      logic [7:0] e;
      bus.BUS_WE      = we;
      bus.BUS_ADDR    = addr;
      bus.BUS_DATA_IN = data;
      rd_q.push_back(exp);
      @(posedge CLK);
      #1;
      e = rd_q.pop_front();
      check(name, 32'(bus.BUS_DATA_OUT), 32'(e));
      @(negedge CLK);
      bus.BUS_WE   = 1'b0;
      bus.BUS_ADDR = 8'h00;
   endtask

   task automatic wait_raise(int budget, logic [2:0] id,
                             string name, output int cycles);
      bit found = 1'b0;
      cycles = 0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge CLK);
         if (bus.CPU_INT_RAISE) begin
            found  = 1'b1;
            cycles = k;
            break;
         end
      end
      check({name, "_raise"}, 32'(found), 32'd1);
      if (found) check({name, "_id"}, 32'(bus.CPU_INT_ID), 32'(id));
   endtask

   task automatic do_ack(logic [3:0] exp, string name);
      ack_q.push_back(exp);
      bus.CPU_INT_ACK = 1'b1;
      @(negedge CLK);
      bus.CPU_INT_ACK = 1'b0;
      check({name, "_raise_low"}, 32'(bus.CPU_INT_RAISE), 32'd0);
   endtask

   always @(negedge CLK) begin
      if (!RESET && IRQ_ACK_OUT != 4'd0) begin
         if (ack_q.size() == 0)
            check("unexpected_ack", 32'(IRQ_ACK_OUT), 32'd0);
         else
            check("ack_pulse", 32'(IRQ_ACK_OUT), 32'(ack_q.pop_front()));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      int c;
      vecs[0]  = '{1'b0, 8'hC0, 8'h00, 8'h00};
      vecs[1]  = '{1'b0, 8'hC1, 8'h00, 8'h00};
      vecs[2]  = '{1'b1, 8'hC0, 8'h0F, 8'h00};
      vecs[3]  = '{1'b0, 8'hC0, 8'h00, 8'h0F};
      vecs[4]  = '{1'b1, 8'hC0, 8'hFA, 8'h00};
      vecs[5]  = '{1'b0, 8'hC0, 8'h00, 8'h0A};
      vecs[6]  = '{1'b1, 8'hC1, 8'hFF, 8'h00};
      vecs[7]  = '{1'b0, 8'hC1, 8'h00, 8'h00};
      vecs[8]  = '{1'b0, 8'h55, 8'h00, 8'h00};
      vecs[9]  = '{1'b1, 8'hC0, 8'h00, 8'h00};
      vecs[10] = '{1'b0, 8'hC0, 8'h00, 8'h00};

      bus.CPU_INT_ACK = 1'b0;
      bus.BUS_ADDR    = 8'h00;
      bus.BUS_DATA_IN = 8'h00;
      bus.BUS_WE      = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_raise", 32'(bus.CPU_INT_RAISE), 32'd0);
      check("rst_id", 32'(bus.CPU_INT_ID), 32'd0);
      check("rst_ack", 32'(IRQ_ACK_OUT), 32'd0);
      check("rst_data", 32'(bus.BUS_DATA_OUT), 32'd0);
      RESET = 1'b0;
      @(negedge CLK);

      foreach (vecs[i])
         bus_cycle(vecs[i].we, vecs[i].addr, vecs[i].data,
                   vecs[i].exp, $sformatf("vec%0d", i));

      // Single source
      IRQ_IN = 4'b0010;
      wait_raise(4, 3'd1, "t1", k);
      IRQ_IN = 4'b0000;
      do_ack(4'b0010, "t1");
      @(negedge CLK);
      bus_cycle(1'b0, 8'hC1, 8'h00, 8'h00, "t1_pend");
      repeat (4) @(negedge CLK);

      // Priority and holdoff gap
      IRQ_IN = 4'b1001;
      wait_raise(4, 3'd0, "t2", k);
      IRQ_IN = 4'b0000;
      do_ack(4'b0001, "t2");
      wait_raise(8, 3'd3, "t2b", k);
      check("t2_gap", 32'(k), 32'(HO + 2));
      do_ack(4'b1000, "t2b");
      repeat (4) @(negedge CLK);

      // Mask
      bus_cycle(1'b1, 8'hC0, 8'h01, 8'h00, "t3_wr");
      IRQ_IN = 4'b0001;
      repeat (3) @(negedge CLK);
      IRQ_IN = 4'b0000;
      repeat (6) @(negedge CLK);
      check("t3_masked", 32'(bus.CPU_INT_RAISE), 32'd0);
      bus_cycle(1'b0, 8'hC1, 8'h00, 8'h01, "t3_pend");
      bus_cycle(1'b0, 8'hC0, 8'h00, 8'h01, "t3_mask");
      bus_cycle(1'b1, 8'hC0, 8'h00, 8'h00, "t3_unmask");
      wait_raise(3, 3'd0, "t3", k);
      do_ack(4'b0001, "t3");
      repeat (4) @(negedge CLK);

      // Timeout
      IRQ_IN = 4'b0100;
      wait_raise(4, 3'd2, "t4", k);
      IRQ_IN = 4'b0000;
      c = 1;
      for (int j = 0; j < 2000 && bus.CPU_INT_RAISE; j++) begin
         @(negedge CLK);
         if (bus.CPU_INT_RAISE) c++;
      end
      check("t4_len", 32'(c), 32'(TMO));
      bus_cycle(1'b0, 8'hC1, 8'h00, 8'h04, "t4_pend");
      wait_raise(6, 3'd2, "t4b", k);
      do_ack(4'b0100, "t4b");
      repeat (4) @(negedge CLK);

      // Edge lands in the ACK cycle of the same source
      IRQ_IN = 4'b0010;
      wait_raise(4, 3'd1, "t5", k);
      IRQ_IN = 4'b0000;
      repeat (4) @(negedge CLK);
      IRQ_IN = 4'b0010;
      ack_q.push_back(4'b0010);
      @(negedge CLK);
      bus.CPU_INT_ACK = 1'b1;
      @(negedge CLK);
      bus.CPU_INT_ACK = 1'b0;
      @(negedge CLK);
      bus_cycle(1'b0, 8'hC1, 8'h00, 8'h02, "t5_pend");
      wait_raise(6, 3'd1, "t5b", k);
      IRQ_IN = 4'b0000;
      do_ack(4'b0010, "t5b");
      @(negedge CLK);
      bus_cycle(1'b0, 8'hC1, 8'h00, 8'h00, "t5_clear");
      repeat (4) @(negedge CLK);

      // Reset mid-raise
      bus_cycle(1'b1, 8'hC0, 8'h08, 8'h00, "t6_wr");
      IRQ_IN = 4'b0010;
      wait_raise(4, 3'd1, "t6", k);
      IRQ_IN = 4'b0000;
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("t6_raise", 32'(bus.CPU_INT_RAISE), 32'd0);
      check("t6_id", 32'(bus.CPU_INT_ID), 32'd0);
      check("t6_ack", 32'(IRQ_ACK_OUT), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (6) @(negedge CLK);
      check("t6_idle", 32'(bus.CPU_INT_RAISE), 32'd0);
      bus_cycle(1'b0, 8'hC0, 8'h00, 8'h00, "t6_mask");
      bus_cycle(1'b0, 8'hC1, 8'h00, 8'h00, "t6_pend");

      check("ack_q_empty", 32'(ack_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
